// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use bubbles, branch flushes and multi-cycle EX holds,
// plus saturating stall and flush counters.
module hazard_ctrl #(
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ifid_regs,
    input  logic [4:0]       ifid_regt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_regt,
    input  logic             mc_start,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             mc_busy,
    output logic             mc_abort,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned MC_W     = $clog2(MC_LAT) + 1;
    localparam bit          MC_MULTI = (MC_LAT > 1);
    localparam logic [MC_W-1:0] MC_INIT = MC_MULTI ? MC_W'(MC_LAT - 2) : '0;

    typedef enum logic [0:0] {StRun, StMcBusy} state_e;

    state_e          state_q, state_d;
    logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;
    logic            load_use;

    // rt of 0 is the zero register, so a load to it never creates a dependency.
    assign load_use = idex_memread && (idex_regt != 5'd0) &&
                      ((idex_regt == ifid_regs) || (idex_regt == ifid_regt));

    always_comb begin
        state_d     = state_q;
        mc_cnt_d    = mc_cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        mc_busy     = 1'b0;
        mc_abort    = 1'b0;
        if (!rst_i) begin
            state_d  = StRun;
            mc_cnt_d = '0;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            mc_abort    = (state_q == StMcBusy);
            state_d     = StRun;
            mc_cnt_d    = '0;
        end else if (state_q == StMcBusy) begin
            // ID is frozen while EX is occupied, so load-use is not evaluated here.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_flush = 1'b1;
            mc_busy     = 1'b1;
            if (mc_cnt_q == '0) begin
                state_d = StRun;
            end else begin
                mc_cnt_d = mc_cnt_q - MC_W'(1);
            end
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end else if (mc_start && MC_MULTI) begin
            state_d  = StMcBusy;
            mc_cnt_d = MC_INIT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= StRun;
            mc_cnt_q  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
            if (!pc_write && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (branch_taken && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
